multicycle_main_control: RTL and testbench

//  Multi-cycle main control FSM for the mini-MIPS core; successor to the single-cycle opcode decoder.

---
 rtl/mips_ctl_pkg.sv | 44 ++++
 rtl/mips_op_decode.sv | 43 ++++
 rtl/multicycle_main_control.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the mini-MIPS multi-cycle control path.
// Used by the control FSM, the datapath and the bench.
package mips_ctl_pkg;

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   localparam logic [3:0] OP_ADD     = 4'h0;
   localparam logic [3:0] OP_SUB     = 4'h1;
   localparam logic [3:0] OP_AND     = 4'h2;
   localparam logic [3:0] OP_OR      = 4'h3;
   localparam logic [3:0] OP_NOR     = 4'h4;
   localparam logic [3:0] OP_NAND    = 4'h5;
   localparam logic [3:0] OP_SLT     = 4'h6;
   localparam logic [3:0] OP_ADDI    = 4'h7;
   localparam logic [3:0] OP_LW      = 4'h8;
   localparam logic [3:0] OP_SW      = 4'h9;
   localparam logic [3:0] OP_BEQ     = 4'hA;
   localparam logic [3:0] OP_BNE     = 4'hB;
   localparam logic [3:0] OP_ILL_MIN = 4'hC;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NAND = 4'b1101;
   localparam logic [3:0] ALU_SLT  = 4'b0111;

   localparam logic [1:0] SRCB_RT  = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_OUT = 2'b01;

endpackage

// File: rtl/mips_op_decode.sv
// Opcode classifier and R-type ALU function lookup.
// Purely combinational; fed from the latched opcode.
module mips_op_decode
   import mips_ctl_pkg::*;
#(
   parameter int OPW   = 4,
   parameter int ALUCW = 4
) (
   input  logic [OPW-1:0]   op,
   output logic             is_rtype,
   output logic             is_imm,
   output logic             is_lw,
   output logic             is_sw,
   output logic             is_beq,
   output logic             is_bne,
   output logic             illegal,
   output logic [ALUCW-1:0] alu_ctl
);

   logic [3:0] alu4;

   always_comb begin
      is_rtype = (op <= OPW'(OP_SLT));
      is_imm   = (op == OPW'(OP_ADDI));
      is_lw    = (op == OPW'(OP_LW));
      is_sw    = (op == OPW'(OP_SW));
      is_beq   = (op == OPW'(OP_BEQ));
      is_bne   = (op == OPW'(OP_BNE));
      illegal  = (op >= OPW'(OP_ILL_MIN));
      alu4     = ALU_ADD;
      unique case (1'b1)
         op == OPW'(OP_SUB):  alu4 = ALU_SUB;
         op == OPW'(OP_AND):  alu4 = ALU_AND;
         op == OPW'(OP_OR):   alu4 = ALU_OR;
         op == OPW'(OP_NOR):  alu4 = ALU_NOR;
         op == OPW'(OP_NAND): alu4 = ALU_NAND;
         op == OPW'(OP_SLT):  alu4 = ALU_SLT;
         default:             alu4 = ALU_ADD;
      endcase
      alu_ctl = ALUCW'(alu4);
   end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/exec/mem/wb,
// with memory stall timeout, illegal-op trap and retire counter.
module multicycle_main_control
   import mips_ctl_pkg::*;
#(
   parameter int OPW     = 4,
   parameter int ALUCW   = 4,
   parameter int CNTW    = 16,
   parameter int MEM_TMO = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPW-1:0]   op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [ALUCW-1:0] alu_ctl,
   output logic [2:0]       state,
   output logic             trap,
   output logic             bus_err,
   output logic [CNTW-1:0]  retired
);

   localparam int WCW = $clog2(MEM_TMO + 1);

   state_e          state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [CNTW-1:0] ret_q, ret_d;
   logic            trap_q, trap_d;
   logic            berr_q, berr_d;
   logic            tmo;

   logic             q_rtype, q_imm, q_lw, q_sw;
   logic             q_beq, q_bne, q_illegal;
   logic [ALUCW-1:0] q_alu;

   mips_op_decode #(.OPW(OPW), .ALUCW(ALUCW)) u_dec (
      .op       (op_q),
      .is_rtype (q_rtype),
      .is_imm   (q_imm),
      .is_lw    (q_lw),
      .is_sw    (q_sw),
      .is_beq   (q_beq),
      .is_bne   (q_bne),
      .illegal  (q_illegal),
      .alu_ctl  (q_alu)
   );

   assign tmo = (wcnt_q == WCW'(MEM_TMO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         op_q    <= '0;
         wcnt_q  <= '0;
         ret_q   <= '0;
         trap_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wcnt_q  <= wcnt_d;
         ret_q   <= ret_d;
         trap_q  <= trap_d;
         berr_q  <= berr_d;
      end
   end

   // Wait counter defaults to 0, so it is clear on every entry to FETCH/MEM.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wcnt_d  = '0;
      ret_d   = ret_q;
      trap_d  = trap_q;
      berr_d  = berr_q;
      unique case (state_q)
         S_BOOT: state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (tmo) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               berr_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_DECODE: begin
            op_d = op;
            if (op >= OPW'(OP_ILL_MIN)) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            unique case (1'b1)
               q_illegal: begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
               end
               q_beq, q_bne: begin
                  state_d = S_FETCH;
                  ret_d   = ret_q + CNTW'(1);
               end
               q_lw, q_sw: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (q_sw) begin
                  state_d = S_FETCH;
                  ret_d   = ret_q + CNTW'(1);
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               berr_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            ret_d   = ret_q + CNTW'(1);
         end
         S_TRAP: state_d = S_TRAP;
         default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
         end
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PCSRC_ALU;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_ctl    = '0;
      unique case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_ONE;
            alu_ctl   = ALUCW'(ALU_ADD);
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM;
            alu_ctl   = ALUCW'(ALU_ADD);
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            if (q_rtype) begin
               alu_ctl = q_alu;
            end else if (q_beq || q_bne) begin
               alu_ctl  = ALUCW'(ALU_SUB);
               pc_src   = PCSRC_OUT;
               pc_write = q_beq ? zero : ~zero;
            end else begin
               alu_src_b = SRCB_IMM;
               alu_ctl   = ALUCW'(ALU_ADD);
            end
         end
         S_MEM: begin
            mem_read  = q_lw;
            mem_write = q_sw;
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = q_rtype;
            mem_to_reg = q_lw;
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   assign trap    = trap_q;
   assign bus_err = berr_q;
   assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized instruction-stream bench for multicycle_main_control.
// Expected strobes come from a per-instruction phase model.
module tb_multicycle_main_control;
   import mips_ctl_pkg::*;

   localparam int CNTW = 4;
   localparam int TMO  = 15;
   localparam int WRAP = 1 << CNTW;

   typedef struct packed {
      logic       pcw;
      logic [1:0] pcs;
      logic       irw, mr, mw, rw, rd, m2r, asa;
      logic [1:0] asb;
      logic [3:0] alu;
      logic [2:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] op = '0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic pc_write, ir_write, mem_read, mem_write;
   logic reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_ctl;
   logic [2:0] state;
   logic trap, bus_err;
   logic [CNTW-1:0] retired;
   logic [18:0] dut_v;

   int checks = 0;
   int errors = 0;
   int exp_ret = 0;
   logic exp_trap = 1'b0;
   logic exp_berr = 1'b0;

   logic [3:0] rt_tab [7] = '{ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_NOR, ALU_NAND, ALU_SLT};

   multicycle_main_control #(
      .OPW(4), .ALUCW(4), .CNTW(CNTW), .MEM_TMO(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_src(pc_src), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
      .state(state), .trap(trap), .bus_err(bus_err),
      .retired(retired)
   );

   assign dut_v = {pc_write, pc_src, ir_write, mem_read,
      mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
      alu_src_b, alu_ctl, state};

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".ctl"}, {13'd0, dut_v}, {13'd0, e});
      chk({tag, ".ret"}, {28'd0, retired}, 32'(exp_ret));
      chk({tag, ".trap"}, {30'd0, trap, bus_err},
          {30'd0, exp_trap, exp_berr});
   endtask

   task automatic cyc(input string tag, input exp_t e);
      @(negedge clk);
      chk_all(tag, e);
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      exp_ret = (exp_ret + 1) % WRAP;
   endtask

   task automatic do_reset();
      exp_t e;
      #2 rst_n = 1'b0;
      #1;
      exp_ret  = 0;
      exp_trap = 1'b0;
      exp_berr = 1'b0;
      e = '0;
      e.st = S_BOOT;
      chk_all("rst", e);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("boot", e);
   endtask

   task automatic run_instr(input logic [3:0] o, input logic z,
                            input int fst, input int mst);
      exp_t e;
      for (int i = 0; i <= fst; i++) begin
         if (i == TMO + 1) begin
            exp_trap = 1'b1;
            exp_berr = 1'b1;
            return;
         end
         mem_ready = (i == fst);
         op   = 4'($urandom);
         zero = 1'($urandom);
         e = '0;
         e.st  = S_FETCH;
         e.mr  = 1'b1;
         e.asb = SRCB_ONE;
         e.alu = ALU_ADD;
         e.irw = mem_ready;
         e.pcw = mem_ready;
         cyc("fetch", e);
      end
      op        = o;
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      e = '0;
      e.st  = S_DECODE;
      e.asb = SRCB_IMM;
      e.alu = ALU_ADD;
      cyc("decode", e);
      if (o >= 4'hC) begin
         exp_trap = 1'b1;
         return;
      end
      op        = 4'($urandom);
      zero      = z;
      mem_ready = 1'($urandom);
      e = '0;
      e.st  = S_EXEC;
      e.asa = 1'b1;
      if (o <= 4'd6) begin
         e.alu = rt_tab[int'(o)];
      end else if (o == OP_BEQ || o == OP_BNE) begin
         e.alu = ALU_SUB;
         e.pcs = PCSRC_OUT;
         e.pcw = (o == OP_BEQ) ? z : !z;
      end else begin
         e.asb = SRCB_IMM;
         e.alu = ALU_ADD;
      end
      cyc("exec", e);
      if (o == OP_BEQ || o == OP_BNE) begin
         retire();
         return;
      end
      if (o == OP_LW || o == OP_SW) begin
         for (int i = 0; i <= mst; i++) begin
            if (i == TMO + 1) begin
               exp_trap = 1'b1;
               exp_berr = 1'b1;
               return;
            end
            mem_ready = (i == mst);
            op   = 4'($urandom);
            zero = 1'($urandom);
            e = '0;
            e.st = S_MEM;
            e.mr = (o == OP_LW);
            e.mw = (o == OP_SW);
            cyc("mem", e);
         end
         if (o == OP_SW) begin
            retire();
            return;
         end
      end
      op        = 4'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      e = '0;
      e.st  = S_WB;
      e.rw  = 1'b1;
      e.rd  = (o <= 4'd6);
      e.m2r = (o == OP_LW);
      cyc("wb", e);
      retire();
   endtask

   task automatic trap_hold(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         op        = 4'($urandom);
         zero      = 1'($urandom);
         mem_ready = 1'($urandom);
         e = '0;
         e.st = S_TRAP;
         cyc("trap", e);
      end
   endtask

   task automatic mid_reset();
      exp_t e;
      mem_ready = 1'b1;
      e = '0;
      e.st = S_FETCH; e.mr = 1'b1; e.asb = SRCB_ONE;
      e.alu = ALU_ADD; e.irw = 1'b1; e.pcw = 1'b1;
      cyc("mid.fetch", e);
      op = OP_SW;
      e = '0;
      e.st = S_DECODE; e.asb = SRCB_IMM; e.alu = ALU_ADD;
      cyc("mid.decode", e);
      e = '0;
      e.st = S_EXEC; e.asa = 1'b1; e.asb = SRCB_IMM;
      e.alu = ALU_ADD;
      cyc("mid.exec", e);
      mem_ready = 1'b0;
      @(negedge clk);
      chk("mid.mw_pre", {31'd0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      exp_ret = 0;
      e = '0;
      e.st = S_BOOT;
      chk_all("mid.rst", e);
      @(posedge clk);
      #1;
      chk_all("mid.hold", e);
      rst_n = 1'b1;
      cyc("mid.boot", e);
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      run_instr(OP_ADD, 1'b0, 0, 0);
      run_instr(OP_LW, 1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BNE, 1'b1, 0, 0);
      run_instr(OP_BEQ, 1'b0, 1, 0);
      run_instr(OP_SW, 1'b0, 2, TMO);
      run_instr(OP_ADDI, 1'b0, TMO, 0);
      repeat (60) begin
         run_instr(4'($urandom_range(0, 11)), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 4));
      end
      run_instr(4'hE, 1'b0, 0, 0);
      trap_hold(20);
      do_reset();
      run_instr(OP_NOR, 1'b0, 0, 0);
      run_instr(OP_ADD, 1'b0, TMO + 1, 0);
      trap_hold(5);
      do_reset();
      run_instr(OP_LW, 1'b0, 0, TMO + 1);
      trap_hold(5);
      do_reset();
      run_instr(OP_OR, 1'b0, 0, 0);
      mid_reset();
      run_instr(OP_SLT, 1'b0, 1, 0);
      run_instr(OP_SW, 1'b0, 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
